// File: rtl/bus_ram.sv
// Single-port word RAM behind a simple valid/ready bus with WAIT wait states.
// Define BUS_RAM_ERR_EN to add the err output for out-of-window/misaligned accesses.
module bus_ram #(
  parameter logic [31:0] BASE = 32'h1000,
  parameter int          AW   = 10,
  parameter int          WAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
`ifdef BUS_RAM_ERR_EN
  output logic        err,
`endif
  output logic [1:0]  state_dbg
);

  // Handshake: a request is accepted when valid is high in IDLE; exactly one
  // ready pulse follows WAIT+1 cycles later, and valid is ignored until then.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAITST = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int         SH      = AW + 2;
  localparam logic [3:0] WAIT_M1 = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  state_t      state;
  logic [3:0]  cnt;
  logic        cap_write;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [2:0]  cap_size;

  logic        cur_write;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [2:0]  cur_size;
  logic [32:0] off;
  logic        in_win;
  logic        misalign;
  logic        enter_resp;
  logic [3:0]  be;
  logic [AW-1:0] widx;

  logic [31:0] mem [2**AW];

  assign state_dbg = state;

  // With WAIT=0 the access completes on the capturing edge, so decode the live inputs in IDLE.
  always_comb begin
    cur_write  = (state == IDLE) ? write : cap_write;
    cur_addr   = (state == IDLE) ? addr  : cap_addr;
    cur_wdata  = (state == IDLE) ? wdata : cap_wdata;
    cur_size   = (state == IDLE) ? size  : cap_size;
    off        = {1'b0, cur_addr} - {1'b0, BASE};
    in_win     = !off[32] && ((off[31:0] >> SH) == 32'd0);
    widx       = off[AW+1:2];
    misalign   = (cur_size == 3'd1 && cur_addr[0]) ||
                 (cur_size == 3'd2 && cur_addr[1:0] != 2'b00) ||
                 (cur_size >= 3'd3);
    case (cur_size)
      3'd0:    be = 4'b0001 << cur_addr[1:0];
      3'd1:    be = 4'b0011 << cur_addr[1:0];
      3'd2:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    enter_resp = (state == IDLE && valid && (WAIT == 0)) ||
                 (state == WAITST && cnt == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst && enter_resp && cur_write && in_win && !misalign) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      ready     <= 1'b0;
      rdata     <= 32'd0;
      cap_write <= 1'b0;
      cap_addr  <= 32'd0;
      cap_wdata <= 32'd0;
      cap_size  <= 3'd0;
`ifdef BUS_RAM_ERR_EN
      err       <= 1'b0;
`endif
    end else begin
      ready <= 1'b0;
`ifdef BUS_RAM_ERR_EN
      err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (valid) begin
            cap_write <= write;
            cap_addr  <= addr;
            cap_wdata <= wdata;
            cap_size  <= size;
            if (WAIT == 0) begin
              state <= RESP;
            end else begin
              state <= WAITST;
              cnt   <= WAIT_M1;
            end
          end
        end
        WAITST: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (enter_resp) begin
        ready <= 1'b1;
`ifdef BUS_RAM_ERR_EN
        err   <= !in_win || misalign;
`endif
        // Misaligned reads leave rdata untouched; aligned out-of-window reads return zero.
        if (!cur_write && !misalign) rdata <= in_win ? mem[widx] : 32'd0;
      end
    end
  end

endmodule
